// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a data requester. Data has fixed priority. Each access is granted from
// IDLE, holds the shared-port registers stable, and ends on mem_rdy or on a
// wait-cycle timeout. Sticky done flags keep a completed request from being
// re-issued while the pipeline is still stalled on the other port.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        ice,
  input  logic [31:0] iaddr,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        dce,
  input  logic [31:0] daddr,
  input  logic [3:0]  dre,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        d_valid,
  output logic        stall_req,
  output logic        bus_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rdy,
  input  logic [31:0] mem_rdata
);

  // Nine bits so the comparison below never wraps for TIMEOUT up to 255.
  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       i_done;
  logic       d_done;
  logic [7:0] wait_cnt;
  logic       d_pend;
  logic       i_pend;
  logic       d_grant;
  logic       i_grant;
  logic       timed_out;
  logic       d_finish;
  logic       i_finish;

  assign d_pend    = dce & ~d_done;
  assign i_pend    = ice & ~i_done;
  assign stall_req = d_pend | i_pend;

  // Decoded purely from the state register: no input-to-mem_req path.
  assign mem_req   = (state == D_ACC) | (state == I_ACC);

  // This wait cycle would bring the counter up to TIMEOUT.
  assign timed_out = mem_req & ~mem_rdy & (({1'b0, wait_cnt} + 9'd1) == TIMEOUT_LIM);
  assign d_finish  = (state == D_ACC) & (mem_rdy | timed_out);
  assign i_finish  = (state == I_ACC) & (mem_rdy | timed_out);

  // Next state: data beats fetch in IDLE; an access always returns to IDLE.
  always_comb begin
    state_next = state;
    d_grant    = 1'b0;
    i_grant    = 1'b0;
    case (state)
      IDLE: begin
        if (d_pend) begin
          state_next = D_ACC;
          d_grant    = 1'b1;
        end else if (i_pend) begin
          state_next = I_ACC;
          i_grant    = 1'b1;
        end
      end
      D_ACC, I_ACC: begin
        if (mem_rdy | timed_out) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset drops any access in flight.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Shared-port registers load only on a grant and hold until the next one.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      mem_addr  <= '0;
      mem_we    <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else if (d_grant) begin
      mem_addr  <= daddr;
      mem_we    <= we;
      mem_be    <= dre;
      mem_wdata <= din;
    end else if (i_grant) begin
      mem_addr  <= iaddr;
      mem_we    <= 4'b0000;
      mem_be    <= 4'b1111;
      mem_wdata <= '0;
    end
  end

  // Wait counter: cleared on grant, counts access cycles without mem_rdy.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      wait_cnt <= '0;
    end else if (d_grant | i_grant) begin
      wait_cnt <= '0;
    end else if (mem_req & ~mem_rdy) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Done flags: cleared whenever the pipeline is not stalled, set on completion.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else if (!stall_req) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      if (d_finish) d_done <= 1'b1;
      if (i_finish) i_done <= 1'b1;
    end
  end

  // Result registers and one-cycle pulses; a timeout delivers zero.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      inst       <= '0;
      dout       <= '0;
      inst_valid <= 1'b0;
      d_valid    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      inst_valid <= i_finish;
      d_valid    <= d_finish;
      bus_err    <= timed_out;
      if (i_finish) begin
        inst <= timed_out ? 32'h0 : mem_rdata;
      end
      if (d_finish) begin
        if (timed_out) begin
          dout <= 32'h0;
        end else if (|mem_be) begin
          dout <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, a transaction-level reference
// model compared against every output on every falling edge, and literal
// expectations for the key results.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ice;
  logic [31:0] iaddr;
  logic [31:0] inst;
  logic        inst_valid;
  logic        dce;
  logic [31:0] daddr;
  logic [3:0]  dre;
  logic [3:0]  we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        d_valid;
  logic        stall_req;
  logic        bus_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rdy;
  logic [31:0] mem_rdata;

  logic        auto_rdy = 1'b0;
  logic        force_rdy = 1'b0;
  int          resp_lat = 0;
  int          acc_cyc = 0;

  int          n_checks = 0;
  int          n_fail = 0;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .cpu_clk_50M(clk),
    .cpu_rst    (rst),
    .ice        (ice),
    .iaddr      (iaddr),
    .inst       (inst),
    .inst_valid (inst_valid),
    .dce        (dce),
    .daddr      (daddr),
    .dre        (dre),
    .we         (we),
    .din        (din),
    .dout       (dout),
    .d_valid    (d_valid),
    .stall_req  (stall_req),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdy    (mem_rdy),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents seen by the arbiter.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h2402_0005;
      32'h0000_0102: return 32'h1122_3344;
      default:       return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  assign mem_rdata = mem_word(mem_addr);
  assign mem_rdy   = auto_rdy | force_rdy;

  // Memory responder: answers in the resp_lat-th access cycle (0 = never).
  always @(posedge clk) begin
    #2;
    if (mem_req) acc_cyc = acc_cyc + 1;
    else         acc_cyc = 0;
    auto_rdy = mem_req && (resp_lat != 0) && (acc_cyc == resp_lat);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_port: 0 = no access, 1 = serving data, 2 = serving fetch.
  int          m_port = 0;
  int          m_waited = 0;
  bit          m_d_done = 0, m_i_done = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_inst = '0, m_dout = '0;
  logic [3:0]  m_we = '0, m_be = '0;
  bit          m_ivld = 0, m_dvld = 0, m_berr = 0;
  bit          want_d, want_i, stalled, fin_d, fin_i, deliver;
  logic [31:0] result;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_port = 0; m_waited = 0; m_d_done = 0; m_i_done = 0;
      m_addr = '0; m_wdata = '0; m_inst = '0; m_dout = '0; m_we = '0; m_be = '0;
      m_ivld = 0; m_dvld = 0; m_berr = 0;
    end else begin
      want_d  = dce && !m_d_done;
      want_i  = ice && !m_i_done;
      stalled = want_d || want_i;
      m_ivld = 0; m_dvld = 0; m_berr = 0; fin_d = 0; fin_i = 0;
      if (m_port == 0) begin
        if (want_d) begin
          m_port = 1; m_waited = 0;
          m_addr = daddr; m_we = we; m_be = dre; m_wdata = din;
        end else if (want_i) begin
          m_port = 2; m_waited = 0;
          m_addr = iaddr; m_we = 4'h0; m_be = 4'hF; m_wdata = '0;
        end
      end else begin
        deliver = 0; result = '0;
        if (mem_rdy) begin
          deliver = 1; result = mem_rdata;
        end else begin
          m_waited = m_waited + 1;
          if (m_waited >= TO) begin
            deliver = 1; result = '0; m_berr = 1;
          end
        end
        if (deliver) begin
          if (m_port == 1) begin
            if (!mem_rdy || m_be != 4'h0) m_dout = result;
            m_dvld = 1; fin_d = 1;
          end else begin
            m_inst = result; m_ivld = 1; fin_i = 1;
          end
          m_port = 0;
        end
      end
      if (!stalled) begin
        m_d_done = 0; m_i_done = 0;
      end else begin
        if (fin_d) m_d_done = 1;
        if (fin_i) m_i_done = 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("stall_req",  32'(stall_req),  32'((dce && !m_d_done) || (ice && !m_i_done)));
    chk("mem_req",    32'(mem_req),    32'(m_port != 0));
    chk("mem_addr",   mem_addr,        m_addr);
    chk("mem_we",     32'(mem_we),     32'(m_we));
    chk("mem_be",     32'(mem_be),     32'(m_be));
    chk("mem_wdata",  mem_wdata,       m_wdata);
    chk("inst",       inst,            m_inst);
    chk("dout",       dout,            m_dout);
    chk("inst_valid", 32'(inst_valid), 32'(m_ivld));
    chk("d_valid",    32'(d_valid),    32'(m_dvld));
    chk("bus_err",    32'(bus_err),    32'(m_berr));
  end

  // Counts falling edges before the chosen valid pulse is seen (bounded).
  task automatic wait_pulse(input bit is_data, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      if (is_data ? d_valid : inst_valid) break;
      n++;
    end
  endtask

  int n;
  int pulses;

  initial begin
    rst = 1'b1; ice = 1'b0; iaddr = '0; dce = 1'b0; daddr = '0;
    dre = '0; we = '0; din = '0; resp_lat = 3;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_dout", dout, 32'h0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    #1 ice = 1'b1;
    #1 chk("rst_stall_comb", 32'(stall_req), 32'd1);
    ice = 1'b0;
    @(posedge clk); #2 rst = 1'b0;

    // Fetch only, ready on the third access cycle
    @(posedge clk); #2 ice = 1'b1; iaddr = 32'h40; resp_lat = 3;
    wait_pulse(1'b0, 20, n);
    chk("fetch_latency", 32'(n), 32'd4);
    chk("fetch_inst", inst, 32'h2402_0005);
    chk("fetch_stall_drop", 32'(stall_req), 32'd0);
    #1 ice = 1'b0;
    @(negedge clk);
    chk("fetch_vld_once", 32'(inst_valid), 32'd0);

    // Simultaneous requests: data first, one IDLE gap, then fetch
    @(posedge clk); #2
    ice = 1'b1; iaddr = 32'h80; dce = 1'b1; daddr = 32'h100;
    we = 4'hF; din = 32'hDEAD_BEEF; dre = 4'h0; resp_lat = 2;
    @(negedge clk);
    @(negedge clk);
    chk("sim_d_req", 32'(mem_req), 32'd1);
    chk("sim_d_addr", mem_addr, 32'h100);
    chk("sim_d_we", 32'(mem_we), 32'hF);
    chk("sim_d_wdata", mem_wdata, 32'hDEAD_BEEF);
    wait_pulse(1'b1, 20, n);
    chk("sim_d_latency", 32'(n), 32'd1);
    chk("sim_gap_req", 32'(mem_req), 32'd0);
    chk("sim_gap_stall", 32'(stall_req), 32'd1);
    wait_pulse(1'b0, 20, n);
    chk("sim_i_latency", 32'(n), 32'd2);
    chk("sim_inst", inst, 32'hC0DE_0080);
    chk("sim_i_addr", mem_addr, 32'h80);
    chk("sim_i_be", 32'(mem_be), 32'hF);
    chk("sim_i_we", 32'(mem_we), 32'h0);
    chk("sim_stall_end", 32'(stall_req), 32'd0);
    #1 ice = 1'b0; dce = 1'b0; we = 4'h0; din = '0;

    // Byte load, then the pipeline advances straight into a write
    @(posedge clk); #2 dce = 1'b1; daddr = 32'h102; dre = 4'b0010; resp_lat = 1;
    @(negedge clk);
    @(negedge clk);
    chk("byte_be", 32'(mem_be), 32'h2);
    chk("byte_addr", mem_addr, 32'h102);
    wait_pulse(1'b1, 20, n);
    chk("byte_latency", 32'(n), 32'd0);
    chk("byte_dout", dout, 32'h1122_3344);
    #1 daddr = 32'h200; dre = 4'h0; we = 4'b0011; din = 32'h55AA_55AA; resp_lat = 2;
    @(negedge clk);
    chk("adv_vld_once", 32'(d_valid), 32'd0);
    chk("adv_no_reissue", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("adv_new_req", 32'(mem_req), 32'd1);
    chk("adv_new_addr", mem_addr, 32'h200);
    chk("adv_new_we", 32'(mem_we), 32'h3);
    wait_pulse(1'b1, 20, n);
    chk("write_latency", 32'(n), 32'd1);
    chk("write_keeps_dout", dout, 32'h1122_3344);
    #1 dce = 1'b0; we = 4'h0;

    // mem_rdy while idle is ignored
    @(posedge clk); #2 force_rdy = 1'b1;
    @(posedge clk); #2 force_rdy = 1'b0;
    @(negedge clk);
    chk("idle_rdy_dvld", 32'(d_valid), 32'd0);
    chk("idle_rdy_ivld", 32'(inst_valid), 32'd0);
    chk("idle_rdy_dout", dout, 32'h1122_3344);

    // Data timeout: never ready
    @(posedge clk); #2 dce = 1'b1; daddr = 32'h300; dre = 4'hF; resp_lat = 0;
    wait_pulse(1'b1, 20, n);
    chk("dto_latency", 32'(n), 32'd5);
    chk("dto_bus_err", 32'(bus_err), 32'd1);
    chk("dto_dout", dout, 32'h0);
    chk("dto_idle", 32'(mem_req), 32'd0);
    #1 dce = 1'b0;
    @(negedge clk);
    chk("dto_err_once", 32'(bus_err), 32'd0);

    // Fetch timeout
    @(posedge clk); #2 ice = 1'b1; iaddr = 32'h44;
    wait_pulse(1'b0, 20, n);
    chk("ito_latency", 32'(n), 32'd5);
    chk("ito_bus_err", 32'(bus_err), 32'd1);
    chk("ito_inst", inst, 32'h0);
    #1 ice = 1'b0;

    // Reset in the middle of a data access, late mem_rdy afterwards
    @(posedge clk); #2 dce = 1'b1; daddr = 32'h400; dre = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_req", 32'(mem_req), 32'd1);
    @(posedge clk); #2 rst = 1'b1; dce = 1'b0;
    #1 chk("rstmid_req_drop", 32'(mem_req), 32'd0);
    chk("rstmid_addr", mem_addr, 32'h0);
    @(posedge clk); #2 rst = 1'b0; force_rdy = 1'b1;
    @(posedge clk); #2 force_rdy = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (d_valid) pulses++;
    end
    chk("rstmid_no_dvld", 32'(pulses), 32'd0);
    chk("rstmid_dout", dout, 32'h0);

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
